snake_core: RTL

SNAKE_CORE -- requirements
Module: snake_core

---
 rtl/snake_core.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/snake_core.sv
// Snake game engine: grid state, collision, food placement and game FSM.
// Define SNAKE_WALL_WRAP_EN to wrap the head around the grid edges.
module snake_core #(
    parameter int GRID_W    = 16,
    parameter int GRID_H    = 16,
    parameter int MAX_LEN   = 64,
    parameter int START_LEN = 3,
    localparam int XW    = $clog2(GRID_W),
    localparam int YW    = $clog2(GRID_H),
    localparam int POS_W = XW + YW,
    localparam int LEN_W = $clog2(MAX_LEN + 1)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     tick,
    input  logic                     start,
    input  logic                     dir_valid,
    input  logic [1:0]               dir,
    output logic [MAX_LEN*POS_W-1:0] positions,
    output logic [LEN_W-1:0]         length,
    output logic [POS_W-1:0]         food_pos,
    output logic [LEN_W-1:0]         score,
    output logic                     running,
    output logic                     game_over,
    output logic                     win,
    output logic                     step_done
);

    typedef enum logic [1:0] {IDLE, RUN, SEEK, OVER} state_t;

    localparam logic [1:0]  UP        = 2'd0;
    localparam logic [1:0]  RIGHT     = 2'd1;
    localparam logic [1:0]  DOWN      = 2'd2;
    localparam logic [1:0]  LEFT      = 2'd3;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;

`ifdef SNAKE_WALL_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    state_t state, state_d;

    logic [POS_W-1:0] seg [MAX_LEN];
    logic [1:0]       pend_dir, appl_dir, eff_dir;
    logic [15:0]      lfsr, lfsr_next;
    logic             dir_ok;

    logic [XW-1:0]    hx, nx;
    logic [YW-1:0]    hy, ny;
    logic [POS_W-1:0] next_head, cand;
    logic [LEN_W-1:0] len_d;
    logic             edge_hit, hit_wall, eat, full_eat;
    logic             collide, cand_hit, do_step, load_init;
    logic             running_d, over_d;

    assign dir_ok  = dir_valid && (dir != (appl_dir ^ 2'd2));
    assign eff_dir = dir_ok ? dir : pend_dir;

    assign hx = seg[0][XW-1:0];
    assign hy = seg[0][POS_W-1:XW];

    // Power-of-two grid: plain add/sub already wraps; the edge flag decides.
    always_comb begin
        nx       = hx;
        ny       = hy;
        edge_hit = 1'b0;
        case (eff_dir)
            UP: begin
                ny       = hy - 1'b1;
                edge_hit = (hy == '0);
            end
            RIGHT: begin
                nx       = hx + 1'b1;
                edge_hit = (hx == XW'(GRID_W - 1));
            end
            DOWN: begin
                ny       = hy + 1'b1;
                edge_hit = (hy == YW'(GRID_H - 1));
            end
            default: begin
                nx       = hx - 1'b1;
                edge_hit = (hx == '0);
            end
        endcase
    end

    assign next_head = {ny, nx};
    assign hit_wall  = edge_hit && !WRAP;
    assign eat       = (next_head == food_pos);
    assign full_eat  = (length == LEN_W'(MAX_LEN - 1));
    assign len_d     = eat ? length + 1'b1 : length;

    // The tail vacates its cell this step unless the snake grows.
    always_comb begin
        collide = 1'b0;
        for (int i = 1; i < MAX_LEN; i++) begin
            if (i < int'(length) && (i != int'(length) - 1 || eat) &&
                seg[i] == next_head)
                collide = 1'b1;
        end
    end

    assign cand      = lfsr[POS_W-1:0];
    assign lfsr_next = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};

    always_comb begin
        cand_hit = 1'b0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if (i < int'(length) && seg[i] == cand)
                cand_hit = 1'b1;
        end
    end

    assign do_step   = (state == RUN) && tick && !hit_wall && !collide;
    assign load_init = reset || (state == OVER && start);

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_d;
    end

    always_comb begin
        state_d = state;
        unique case (state)
            IDLE: if (start) state_d = RUN;
            RUN: begin
                if (tick) begin
                    if (hit_wall || collide)
                        state_d = OVER;
                    else if (eat)
                        state_d = full_eat ? OVER : SEEK;
                end
            end
            SEEK: if (!cand_hit) state_d = RUN;
            OVER: if (start) state_d = RUN;
        endcase
    end

    always_comb begin
        running_d = (state_d == RUN) || (state_d == SEEK);
        over_d    = (state_d == OVER);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            running   <= 1'b0;
            game_over <= 1'b0;
        end else begin
            running   <= running_d;
            game_over <= over_d;
        end
    end

    always_ff @(posedge clk) begin
        step_done <= 1'b0;
        if (load_init) begin
            for (int i = 0; i < MAX_LEN; i++)
                seg[i] <= (i < START_LEN) ?
                          {YW'(GRID_H / 2), XW'(GRID_W / 2 - i)} : '0;
            length   <= LEN_W'(START_LEN);
            score    <= '0;
            food_pos <= {YW'(GRID_H / 4), XW'(GRID_W / 4)};
            pend_dir <= RIGHT;
            appl_dir <= RIGHT;
            lfsr     <= LFSR_SEED;
            win      <= 1'b0;
        end else begin
            if (dir_ok)
                pend_dir <= dir;
            if (do_step) begin
                for (int i = 1; i < MAX_LEN; i++)
                    seg[i] <= (i < int'(len_d)) ? seg[i-1] : '0;
                seg[0]    <= next_head;
                pend_dir  <= eff_dir;
                appl_dir  <= eff_dir;
                length    <= len_d;
                score     <= len_d - LEN_W'(START_LEN);
                step_done <= 1'b1;
                if (eat && full_eat)
                    win <= 1'b1;
            end
            if (state == SEEK) begin
                lfsr <= lfsr_next;
                if (!cand_hit)
                    food_pos <= cand;
            end
        end
    end

    always_comb begin
        positions = '0;
        for (int i = 0; i < MAX_LEN; i++)
            positions[i*POS_W +: POS_W] = seg[i];
    end

endmodule
